// File: rtl/riscv_i32_debug_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : riscv_i32_debug_sequencer_if
//  Purpose  : Bundles the command, pipeline-debug and response channels of
//             the debug sequencer into one interface.
//  Modports : slave  - the sequencer itself (consumes commands, drives the
//                      pipeline debug fields and the response channel)
//             master - the environment (debug module + pipeline side)
//  Signals  : cmd_*        command request channel (valid/ready)
//             core_halted  core debug-halt indication
//             instruction__* debug instruction fields into the pipeline
//             exec_*       pipeline completion/acknowledge
//             rsp_*        response channel (valid/ready)
//             busy         sequencer not idle
//  Revision : 1.0 - initial release
// ============================================================================
interface riscv_i32_debug_sequencer_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic        cmd_gpr;
    logic [11:0] cmd_regno;
    logic [31:0] cmd_wdata;
    logic        core_halted;
    logic [31:0] instruction__data;
    logic        instruction__debug__valid;
    logic [1:0]  instruction__debug__debug_op;
    logic [15:0] instruction__debug__data;
    logic        exec_ack;
    logic        exec_illegal;
    logic [31:0] exec_rdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_status;
    logic        busy;

    modport slave (
        input  cmd_valid, cmd_write, cmd_gpr, cmd_regno, cmd_wdata,
        input  core_halted, exec_ack, exec_illegal, exec_rdata, rsp_ready,
        output cmd_ready, instruction__data, instruction__debug__valid,
        output instruction__debug__debug_op, instruction__debug__data,
        output rsp_valid, rsp_rdata, rsp_status, busy
    );

    modport master (
        output cmd_valid, cmd_write, cmd_gpr, cmd_regno, cmd_wdata,
        output core_halted, exec_ack, exec_illegal, exec_rdata, rsp_ready,
        input  cmd_ready, instruction__data, instruction__debug__valid,
        input  instruction__debug__debug_op, instruction__debug__data,
        input  rsp_valid, rsp_rdata, rsp_status, busy
    );
endinterface
`default_nettype wire

// File: rtl/riscv_i32_debug_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : riscv_i32_debug_sequencer
//  Purpose  : Turns one abstract register-access command at a time into a
//             single debug instruction for the pipeline, waits for the
//             execute acknowledge (bounded by a watchdog) and returns the
//             read data and status on a valid/ready response channel.
//  Ports    : clk   - clock, rising edge
//             reset - asynchronous, active-high
//             bus   - riscv_i32_debug_sequencer_if.slave (command, pipeline
//                     debug fields, execute ack, response, busy)
//  Params   : TIMEOUT_WIDTH - watchdog width; EXEC gives up after
//                             2^TIMEOUT_WIDTH-1 cycles without acknowledge
//  Revision : 1.0 - initial release
// ============================================================================
module riscv_i32_debug_sequencer #(
    parameter int TIMEOUT_WIDTH = 8
) (
    input  wire logic                        clk,
    input  wire logic                        reset,
    riscv_i32_debug_sequencer_if.slave       bus
);

    localparam logic [1:0] ST_OK        = 2'd0;
    localparam logic [1:0] ST_NOT_HALT  = 2'd1;
    localparam logic [1:0] ST_ILLEGAL   = 2'd2;
    localparam logic [1:0] ST_TIMEOUT   = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_EXEC    = 2'd1,
        S_RESPOND = 2'd2
    } state_t;

    state_t                   state_q;
    logic                     write_q;
    logic                     gpr_q;
    logic [11:0]              regno_q;
    logic [31:0]              wdata_q;
    logic [31:0]              rdata_q;
    logic [1:0]               status_q;
    logic [TIMEOUT_WIDTH-1:0] cnt_q;
    logic [TIMEOUT_WIDTH-1:0] cnt_d;

    // The watchdog fires on the EXEC cycle whose increment reaches all-ones,
    // so the instruction is presented for exactly 2^W-1 cycles.
    assign cnt_d = cnt_q + TIMEOUT_WIDTH'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            write_q  <= 1'b0;
            gpr_q    <= 1'b0;
            regno_q  <= 12'd0;
            wdata_q  <= 32'd0;
            rdata_q  <= 32'd0;
            status_q <= ST_OK;
            cnt_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.cmd_valid) begin
                        write_q <= bus.cmd_write;
                        gpr_q   <= bus.cmd_gpr;
                        regno_q <= bus.cmd_regno;
                        wdata_q <= bus.cmd_wdata;
                        if (bus.core_halted) begin
                            state_q <= S_EXEC;
                            cnt_q   <= '0;
                        end else begin
                            // Refuse without touching the pipeline.
                            state_q  <= S_RESPOND;
                            status_q <= ST_NOT_HALT;
                            rdata_q  <= 32'd0;
                        end
                    end
                end
                S_EXEC: begin
                    // Acknowledge has priority over the terminal count.
                    if (bus.exec_ack) begin
                        state_q <= S_RESPOND;
                        if (bus.exec_illegal) begin
                            status_q <= ST_ILLEGAL;
                            rdata_q  <= 32'd0;
                        end else begin
                            status_q <= ST_OK;
                            rdata_q  <= write_q ? 32'd0 : bus.exec_rdata;
                        end
                    end else begin
                        cnt_q <= cnt_d;
                        if (cnt_d == {TIMEOUT_WIDTH{1'b1}}) begin
                            state_q  <= S_RESPOND;
                            status_q <= ST_TIMEOUT;
                            rdata_q  <= 32'd0;
                        end
                    end
                end
                S_RESPOND: begin
                    if (bus.rsp_ready) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // All outputs are decoded from registers only, so they follow the
    // asynchronous reset immediately.
    assign bus.cmd_ready                    = (state_q == S_IDLE);
    assign bus.busy                         = (state_q != S_IDLE);
    assign bus.instruction__debug__valid    = (state_q == S_EXEC);
    assign bus.instruction__debug__debug_op = {1'b0, write_q};
    assign bus.instruction__debug__data     = {3'b000, gpr_q, regno_q};
    assign bus.instruction__data            = wdata_q;
    assign bus.rsp_valid                    = (state_q == S_RESPOND);
    assign bus.rsp_rdata                    = rdata_q;
    assign bus.rsp_status                   = status_q;

endmodule
`default_nettype wire

// File: tb/tb_riscv_i32_debug_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_riscv_i32_debug_sequencer
//  Purpose  : Self-checking bench for riscv_i32_debug_sequencer: directed
//             scenarios plus randomized commands against a behavioural model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_riscv_i32_debug_sequencer;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    riscv_i32_debug_sequencer_if bus();

    riscv_i32_debug_sequencer #(.TIMEOUT_WIDTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Observations of the last transaction
    int          o_vcyc, o_lat;
    logic [1:0]  o_status;
    logic [31:0] o_rdata;
    bit          o_fields_ok, o_stable_ok, o_idle_ok, o_ready_ok;

    // Expected outcome of one command, derived from the command-level rules.
    function automatic void model(input bit halted, input bit w, input int ack_at,
                                  input bit ill, input logic [31:0] ed,
                                  output logic [1:0] st, output logic [31:0] rd,
                                  output int vcyc, output int lat);
        if (!halted) begin
            st = 2'd1; rd = 32'd0; vcyc = 0; lat = 1;
        end else if (ack_at >= 1 && ack_at <= 255) begin
            vcyc = ack_at; lat = ack_at + 1;
            st   = ill ? 2'd2 : 2'd0;
            rd   = (ill || w) ? 32'd0 : ed;
        end else begin
            st = 2'd3; rd = 32'd0; vcyc = 255; lat = 256;
        end
    endfunction

    // Drives one command through to the response handshake and records what
    // was seen. ack_at: EXEC cycle (1-based) on which exec_ack is raised,
    // 0 = never.
    task automatic do_cmd(input bit w, input bit g, input logic [11:0] rn,
                          input logic [31:0] wd, input bit halted, input int ack_at,
                          input bit ill, input logic [31:0] ed, input int rsp_wait,
                          input bit stray_ack, input bit drop_halt);
        logic [15:0] exp_data;
        bit done;
        exp_data = g ? (16'h1000 | {4'h0, rn}) : {4'h0, rn};
        o_vcyc = 0; o_lat = -1; o_status = 2'd0; o_rdata = 32'd0;
        o_fields_ok = 1'b1; o_stable_ok = 1'b1; o_idle_ok = 1'b1; o_ready_ok = 1'b1;
        bus.cmd_valid = 1'b1; bus.cmd_write = w; bus.cmd_gpr = g;
        bus.cmd_regno = rn; bus.cmd_wdata = wd; bus.core_halted = halted;
        bus.exec_ack = stray_ack; bus.exec_illegal = ill; bus.exec_rdata = ed;
        @(posedge clk); #1;
        // Scramble command inputs after accept: the captured copy must hold.
        bus.cmd_valid = 1'b0; bus.cmd_wdata = $urandom; bus.cmd_regno = 12'($urandom);
        bus.cmd_write = ~w; bus.cmd_gpr = ~g;
        done = 1'b0;
        for (int n = 1; n <= 400 && !done; n++) begin
            if (bus.cmd_ready) o_ready_ok = 1'b0;
            if (bus.rsp_valid) begin
                o_lat = n; done = 1'b1;
                if (bus.instruction__debug__valid) o_fields_ok = 1'b0;
            end else begin
                if (bus.instruction__debug__valid) begin
                    o_vcyc++;
                    if (bus.instruction__debug__data !== exp_data ||
                        bus.instruction__debug__debug_op !== {1'b0, w} ||
                        bus.instruction__data !== wd) o_fields_ok = 1'b0;
                    bus.exec_ack = (o_vcyc == ack_at);
                    if (drop_halt) bus.core_halted = 1'b0;
                end else begin
                    bus.exec_ack = stray_ack;
                end
                @(posedge clk); #1;
            end
        end
        bus.exec_ack = stray_ack;
        if (done) begin
            o_status = bus.rsp_status; o_rdata = bus.rsp_rdata;
            for (int i = 0; i < rsp_wait; i++) begin
                @(posedge clk); #1;
                if (!bus.rsp_valid || bus.rsp_status !== o_status ||
                    bus.rsp_rdata !== o_rdata || bus.cmd_ready) o_stable_ok = 1'b0;
            end
            bus.rsp_ready = 1'b1;
            @(posedge clk); #1;
            bus.rsp_ready = 1'b0;
            if (bus.rsp_valid || !bus.cmd_ready || bus.busy) o_idle_ok = 1'b0;
        end
        bus.exec_ack = 1'b0;
        bus.core_halted = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.cmd_valid = 0; bus.cmd_write = 0; bus.cmd_gpr = 0; bus.cmd_regno = 0;
        bus.cmd_wdata = 0; bus.core_halted = 1; bus.exec_ack = 0; bus.exec_illegal = 0;
        bus.exec_rdata = 0; bus.rsp_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0 || bus.rsp_valid !== 1'b0 ||
            bus.instruction__debug__valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: ready=%b busy=%b rsp_valid=%b valid=%b, required 1 0 0 0",
                     bus.cmd_ready, bus.busy, bus.rsp_valid, bus.instruction__debug__valid);
        end
        n_tests++;
        if (bus.rsp_rdata !== 32'd0 || bus.rsp_status !== 2'd0 || bus.instruction__data !== 32'd0 ||
            bus.instruction__debug__data !== 16'd0 || bus.instruction__debug__debug_op !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_data: rdata=%h status=%0d idata=%h ddata=%h op=%0d, required all 0",
                     bus.rsp_rdata, bus.rsp_status, bus.instruction__data,
                     bus.instruction__debug__data, bus.instruction__debug__debug_op);
        end
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_gpr_read();
        do_cmd(1'b0, 1'b1, 12'd5, 32'h0, 1'b1, 1, 1'b0, 32'hDEADBEEF, 0, 1'b0, 1'b0);
        n_tests++;
        if (o_vcyc != 1 || o_lat != 2 || !o_fields_ok) begin
            n_fail++;
            $display("FAIL gpr_read_issue: valid_cycles=%0d latency=%0d fields_ok=%b, required 1 2 1",
                     o_vcyc, o_lat, o_fields_ok);
        end
        n_tests++;
        if (o_status !== 2'd0 || o_rdata !== 32'hDEADBEEF || !o_idle_ok) begin
            n_fail++;
            $display("FAIL gpr_read_rsp: status=%0d rdata=%h idle_ok=%b, required 0 deadbeef 1",
                     o_status, o_rdata, o_idle_ok);
        end
    endtask

    task automatic test_csr_write_backpressure();
        do_cmd(1'b1, 1'b0, 12'h7B0, 32'h12345678, 1'b1, 3, 1'b0, 32'hCAFEF00D, 4, 1'b0, 1'b0);
        n_tests++;
        if (o_vcyc != 3 || !o_fields_ok || !o_ready_ok) begin
            n_fail++;
            $display("FAIL csr_write_issue: valid_cycles=%0d fields_ok=%b ready_ok=%b, required 3 1 1",
                     o_vcyc, o_fields_ok, o_ready_ok);
        end
        n_tests++;
        if (o_status !== 2'd0 || o_rdata !== 32'd0 || !o_stable_ok || !o_idle_ok) begin
            n_fail++;
            $display("FAIL csr_write_rsp: status=%0d rdata=%h stable=%b idle=%b, required 0 0 1 1",
                     o_status, o_rdata, o_stable_ok, o_idle_ok);
        end
        n_tests++;
        if (bus.instruction__data !== 32'h12345678 || bus.instruction__debug__data !== 16'h07B0 ||
            bus.instruction__debug__debug_op !== 2'd1 || bus.instruction__debug__valid !== 1'b0) begin
            n_fail++;
            $display("FAIL csr_write_hold: idata=%h ddata=%h op=%0d valid=%b, required 12345678 07b0 1 0",
                     bus.instruction__data, bus.instruction__debug__data,
                     bus.instruction__debug__debug_op, bus.instruction__debug__valid);
        end
    endtask

    task automatic test_not_halted();
        // exec_ack is held high throughout and must be ignored.
        do_cmd(1'b0, 1'b1, 12'd9, 32'h0, 1'b0, 1, 1'b0, 32'h55AA55AA, 1, 1'b1, 1'b0);
        n_tests++;
        if (o_vcyc != 0 || o_lat < 1 || o_lat > 2) begin
            n_fail++;
            $display("FAIL not_halted_issue: valid_cycles=%0d latency=%0d, required 0 and 1..2",
                     o_vcyc, o_lat);
        end
        n_tests++;
        if (o_status !== 2'd1 || o_rdata !== 32'd0 || !o_stable_ok || !o_idle_ok) begin
            n_fail++;
            $display("FAIL not_halted_rsp: status=%0d rdata=%h stable=%b idle=%b, required 1 0 1 1",
                     o_status, o_rdata, o_stable_ok, o_idle_ok);
        end
    endtask

    task automatic test_illegal_and_timeout();
        do_cmd(1'b0, 1'b0, 12'h300, 32'h0, 1'b1, 2, 1'b1, 32'hFFFFFFFF, 0, 1'b0, 1'b0);
        n_tests++;
        if (o_status !== 2'd2 || o_rdata !== 32'd0 || o_vcyc != 2) begin
            n_fail++;
            $display("FAIL illegal: status=%0d rdata=%h valid_cycles=%0d, required 2 0 2",
                     o_status, o_rdata, o_vcyc);
        end
        // Halt drops during EXEC: must not matter, watchdog bounds the wait.
        do_cmd(1'b0, 1'b1, 12'd1, 32'h0, 1'b1, 0, 1'b0, 32'h1234, 0, 1'b0, 1'b1);
        n_tests++;
        if (o_vcyc != 255 || o_lat != 256 || o_status !== 2'd3 || o_rdata !== 32'd0 || !o_idle_ok) begin
            n_fail++;
            $display("FAIL timeout: valid_cycles=%0d latency=%0d status=%0d rdata=%h idle=%b, required 255 256 3 0 1",
                     o_vcyc, o_lat, o_status, o_rdata, o_idle_ok);
        end
    endtask

    task automatic test_ack_terminal();
        do_cmd(1'b0, 1'b1, 12'd31, 32'h0, 1'b1, 255, 1'b0, 32'hA5A5_0001, 0, 1'b0, 1'b0);
        n_tests++;
        if (o_vcyc != 255 || o_status !== 2'd0 || o_rdata !== 32'hA5A5_0001) begin
            n_fail++;
            $display("FAIL ack_terminal: valid_cycles=%0d status=%0d rdata=%h, required 255 0 a5a50001",
                     o_vcyc, o_status, o_rdata);
        end
    endtask

    task automatic test_back_to_back();
        do_cmd(1'b1, 1'b1, 12'd7, 32'h0BAD_CAFE, 1'b1, 1, 1'b0, 32'h0, 0, 1'b0, 1'b0);
        do_cmd(1'b0, 1'b1, 12'd8, 32'h0, 1'b1, 1, 1'b0, 32'h8888_0008, 0, 1'b0, 1'b0);
        n_tests++;
        if (o_status !== 2'd0 || o_rdata !== 32'h8888_0008 || o_lat != 2 || !o_fields_ok || !o_ready_ok) begin
            n_fail++;
            $display("FAIL back_to_back: status=%0d rdata=%h latency=%0d fields=%b ready_ok=%b, required 0 88880008 2 1 1",
                     o_status, o_rdata, o_lat, o_fields_ok, o_ready_ok);
        end
    endtask

    task automatic test_random();
        logic [1:0]  e_st;
        logic [31:0] e_rd, wd, ed;
        logic [11:0] rn;
        int e_vc, e_lat, ack_at, wt;
        bit w, g, h, ill, drop;
        for (int k = 0; k < 24; k++) begin
            w = 1'($urandom); g = 1'($urandom); rn = 12'($urandom);
            wd = $urandom; ed = $urandom; ill = ($urandom_range(0, 3) == 0);
            h = ($urandom_range(0, 4) != 0); drop = 1'($urandom);
            ack_at = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 6));
            wt = int'($urandom_range(0, 3));
            model(h, w, ack_at, ill, ed, e_st, e_rd, e_vc, e_lat);
            do_cmd(w, g, rn, wd, h, ack_at, ill, ed, wt, 1'b0, drop);
            n_tests++;
            if (o_status !== e_st || o_rdata !== e_rd || o_vcyc != e_vc ||
                (h && o_lat != e_lat) || (!h && (o_lat < 1 || o_lat > 2)) ||
                !o_fields_ok || !o_stable_ok || !o_idle_ok || !o_ready_ok) begin
                n_fail++;
                $display("FAIL random[%0d]: status=%0d rdata=%h vcyc=%0d lat=%0d f/s/i/r=%b%b%b%b, required %0d %h %0d %0d 1111",
                         k, o_status, o_rdata, o_vcyc, o_lat, o_fields_ok, o_stable_ok,
                         o_idle_ok, o_ready_ok, e_st, e_rd, e_vc, e_lat);
            end
        end
    endtask

    task automatic test_reset_mid_exec();
        bit seen_rsp;
        bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_gpr = 1'b1;
        bus.cmd_regno = 12'd3; bus.core_halted = 1'b1; bus.exec_ack = 1'b0;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        @(posedge clk); #1;
        n_tests++;
        if (bus.instruction__debug__valid !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_exec_pre: valid=%b, required 1", bus.instruction__debug__valid);
        end
        reset = 1'b1;
        #1;
        n_tests++;
        if (bus.instruction__debug__valid !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_exec_async: valid=%b rsp_valid=%b busy=%b, required 0 0 0",
                     bus.instruction__debug__valid, bus.rsp_valid, bus.busy);
        end
        @(negedge clk); reset = 1'b0;
        seen_rsp = 1'b0;
        bus.exec_ack = 1'b1; bus.rsp_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (bus.rsp_valid || bus.instruction__debug__valid || !bus.cmd_ready) seen_rsp = 1'b1;
        end
        bus.exec_ack = 1'b0;
        n_tests++;
        if (seen_rsp) begin
            n_fail++;
            $display("FAIL reset_mid_exec_after: activity after reset=%b, required 0 (idle, ready)", seen_rsp);
        end
    endtask

    initial begin
        test_reset();
        test_gpr_read();
        test_csr_write_backpressure();
        test_not_halted();
        test_illegal_and_timeout();
        test_ack_terminal();
        test_back_to_back();
        test_random();
        test_reset_mid_exec();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
